// File: rtl/csr_wb_sequencer_pkg.sv
// Shared types for the writeback CSR sequencer: instruction types, CSR commands,
// sequencer states and the latched request payload.
package csr_wb_sequencer_pkg;

    localparam int XLEN       = 64;
    localparam int CSR_ADDR_W = 12;

    typedef enum logic [4:0] {
        INSTR_NOP,
        ADD,
        SUB,
        AND_OP,
        OR_OP,
        XOR_OP,
        LOAD,
        STORE,
        BRANCH,
        JAL,
        CSRRW,
        CSRRS,
        CSRRC,
        CSRRWI,
        CSRRSI,
        CSRRCI,
        ECALL,
        EBREAK,
        MRET,
        SRET,
        URET,
        FENCE,
        WFI
    } instr_type_t;

    typedef enum logic [2:0] {
        CSR_CMD_NOPE  = 3'd0,
        CSR_CMD_WRITE = 3'd1,
        CSR_CMD_SET   = 3'd2,
        CSR_CMD_CLEAR = 3'd3,
        CSR_CMD_SYS   = 3'd4,
        CSR_CMD_READ  = 3'd5
    } csr_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE,
        DRAIN
    } csr_seq_state_t;

    typedef struct packed {
        csr_cmd_t              cmd;
        logic [CSR_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
    } csr_wb_req_t;

    // Illegal-instruction cause reported for faulted or timed-out CSR accesses.
    localparam logic [XLEN-1:0] CSR_XCPT_ILLEGAL = 64'd2;

endpackage

// File: rtl/csr_wb_sequencer_cmd_decode.sv
// Combinational decode of the WB instruction into a CSR command and write data.
module csr_cmd_decode
    import csr_wb_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [$bits(instr_type_t)-1:0] instr_type_i,
    input  logic [4:0]                     rs1_i,
    input  logic [DATA_WIDTH-1:0]          result_i,
    output logic [$bits(csr_cmd_t)-1:0]    cmd_o,
    output logic [DATA_WIDTH-1:0]          wdata_o,
    output logic                           is_csr_o
);

    instr_type_t           itype;
    csr_cmd_t              cmd;
    logic [DATA_WIDTH-1:0] zimm;
    logic                  rs1_zero;

    assign itype    = instr_type_t'(instr_type_i);
    assign zimm     = {{(DATA_WIDTH-5){1'b0}}, rs1_i};
    assign rs1_zero = (rs1_i == 5'd0);

    // Set/clear with rs1==0 has no write side effect, so it degrades to a pure read.
    always_comb begin
        cmd      = CSR_CMD_NOPE;
        wdata_o  = '0;
        is_csr_o = 1'b0;
        case (itype)
            CSRRW:  begin cmd = CSR_CMD_WRITE; wdata_o = result_i; is_csr_o = 1'b1; end
            CSRRWI: begin cmd = CSR_CMD_WRITE; wdata_o = zimm;     is_csr_o = 1'b1; end
            CSRRS:  begin cmd = rs1_zero ? CSR_CMD_READ : CSR_CMD_SET;   wdata_o = result_i; is_csr_o = 1'b1; end
            CSRRSI: begin cmd = rs1_zero ? CSR_CMD_READ : CSR_CMD_SET;   wdata_o = zimm;     is_csr_o = 1'b1; end
            CSRRC:  begin cmd = rs1_zero ? CSR_CMD_READ : CSR_CMD_CLEAR; wdata_o = result_i; is_csr_o = 1'b1; end
            CSRRCI: begin cmd = rs1_zero ? CSR_CMD_READ : CSR_CMD_CLEAR; wdata_o = zimm;     is_csr_o = 1'b1; end
            ECALL, EBREAK, MRET, SRET, URET, FENCE: begin
                cmd      = CSR_CMD_SYS;
                is_csr_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_o = cmd;

endmodule

// File: rtl/csr_wb_sequencer.sv
// Writeback CSR sequencer: issues decoded CSR commands over a valid/ready channel,
// stalls WB until a response (or timeout) and then writes back / retires / traps.
module csr_wb_sequencer
    import csr_wb_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int CSR_ADDR_WIDTH   = 12,
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int RETIRE_CNT_WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           flush_i,
    input  logic                           wb_valid_i,
    input  logic [$bits(instr_type_t)-1:0] wb_instr_type_i,
    input  logic [4:0]                     wb_rs1_i,
    input  logic [DATA_WIDTH-1:0]          wb_result_i,
    input  logic [CSR_ADDR_WIDTH-1:0]      wb_csr_addr_i,
    input  logic                           wb_xcpt_i,
    input  logic [DATA_WIDTH-1:0]          wb_xcpt_cause_i,
    input  logic [DATA_WIDTH-1:0]          wb_pc_i,
    output logic                           csr_req_valid_o,
    input  logic                           csr_req_ready_i,
    output logic [$bits(csr_cmd_t)-1:0]    csr_cmd_o,
    output logic [CSR_ADDR_WIDTH-1:0]      csr_addr_o,
    output logic [DATA_WIDTH-1:0]          csr_wdata_o,
    input  logic                           csr_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]          csr_rdata_i,
    input  logic                           csr_resp_xcpt_i,
    output logic                           stall_wb_o,
    output logic                           rf_we_o,
    output logic [DATA_WIDTH-1:0]          rf_wdata_o,
    output logic                           retire_o,
    output logic                           xcpt_o,
    output logic [DATA_WIDTH-1:0]          xcpt_cause_o,
    output logic                           timeout_o,
    output logic [RETIRE_CNT_WIDTH-1:0]    retire_count_o
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    csr_seq_state_t              state_q;
    csr_wb_req_t                 req_q;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic                        done_xcpt_q;
    logic [TMR_W-1:0]            timer_q;
    logic                        timeout_q;
    logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q;

    logic [$bits(csr_cmd_t)-1:0] dec_cmd;
    logic [DATA_WIDTH-1:0]       dec_wdata;
    logic                        dec_is_csr;
    logic                        wb_go;
    logic                        new_csr;
    logic                        tmr_expired;
    logic                        pc_unused;

    csr_cmd_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr_type_i (wb_instr_type_i),
        .rs1_i        (wb_rs1_i),
        .result_i     (wb_result_i),
        .cmd_o        (dec_cmd),
        .wdata_o      (dec_wdata),
        .is_csr_o     (dec_is_csr)
    );

    assign wb_go       = wb_valid_i && !flush_i;
    assign new_csr     = wb_go && !wb_xcpt_i && dec_is_csr;
    assign tmr_expired = (timer_q == TMR_LAST);
    assign pc_unused   = ^wb_pc_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            req_q        <= '{cmd: CSR_CMD_NOPE, addr: '0, wdata: '0};
            rdata_q      <= '0;
            done_xcpt_q  <= 1'b0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_csr) begin
                        req_q.cmd   <= csr_cmd_t'(dec_cmd);
                        req_q.addr  <= wb_csr_addr_i;
                        req_q.wdata <= dec_wdata;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (csr_req_ready_i) begin
                        timer_q <= '0;
                        state_q <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A flush that coincides with the response or expiry has nothing left to drain.
                    if (flush_i) begin
                        timer_q <= timer_q + 1'b1;
                        state_q <= (csr_resp_valid_i || tmr_expired) ? IDLE : DRAIN;
                    end else if (csr_resp_valid_i) begin
                        rdata_q     <= csr_rdata_i;
                        done_xcpt_q <= csr_resp_xcpt_i;
                        state_q     <= DONE;
                    end else if (tmr_expired) begin
                        done_xcpt_q <= 1'b1;
                        timeout_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (csr_resp_valid_i || tmr_expired) state_q <= IDLE;
                    else                                 timer_q <= timer_q + 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (retire_o) retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    // IDLE/DRAIN outputs follow the WB inputs in the same cycle; everything is masked in reset.
    always_comb begin
        csr_req_valid_o = 1'b0;
        csr_cmd_o       = CSR_CMD_NOPE;
        csr_addr_o      = '0;
        csr_wdata_o     = '0;
        stall_wb_o      = 1'b0;
        rf_we_o         = 1'b0;
        rf_wdata_o      = '0;
        retire_o        = 1'b0;
        xcpt_o          = 1'b0;
        xcpt_cause_o    = '0;
        if (rstn_i) begin
            case (state_q)
                IDLE, DRAIN: begin
                    if (wb_go) begin
                        if (wb_xcpt_i) begin
                            xcpt_o       = 1'b1;
                            xcpt_cause_o = wb_xcpt_cause_i;
                        end else if (dec_is_csr) begin
                            stall_wb_o = 1'b1;
                        end else begin
                            retire_o = 1'b1;
                        end
                    end
                end
                REQ: begin
                    stall_wb_o      = 1'b1;
                    csr_req_valid_o = !flush_i;
                    csr_cmd_o       = req_q.cmd;
                    csr_addr_o      = req_q.addr;
                    csr_wdata_o     = req_q.wdata;
                end
                WAIT_RESP: stall_wb_o = 1'b1;
                DONE: begin
                    if (!flush_i) begin
                        if (done_xcpt_q) begin
                            xcpt_o       = 1'b1;
                            xcpt_cause_o = CSR_XCPT_ILLEGAL;
                        end else begin
                            rf_we_o    = 1'b1;
                            rf_wdata_o = rdata_q;
                            retire_o   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign timeout_o      = timeout_q;
    assign retire_count_o = retire_cnt_q;

endmodule

// File: tb/tb_csr_wb_sequencer.sv
// Directed bench for csr_wb_sequencer with hand-computed expectations.
module tb_csr_wb_sequencer;
    import csr_wb_sequencer_pkg::*;

    localparam int TMO = 16;

    logic                           clk = 1'b0;
    logic                           rstn_i;
    logic                           flush_i;
    logic                           wb_valid_i;
    logic [$bits(instr_type_t)-1:0] wb_instr_type_i;
    logic [4:0]                     wb_rs1_i;
    logic [63:0]                    wb_result_i;
    logic [11:0]                    wb_csr_addr_i;
    logic                           wb_xcpt_i;
    logic [63:0]                    wb_xcpt_cause_i;
    logic [63:0]                    wb_pc_i;
    logic                           csr_req_valid_o;
    logic                           csr_req_ready_i;
    logic [$bits(csr_cmd_t)-1:0]    csr_cmd_o;
    logic [11:0]                    csr_addr_o;
    logic [63:0]                    csr_wdata_o;
    logic                           csr_resp_valid_i;
    logic [63:0]                    csr_rdata_i;
    logic                           csr_resp_xcpt_i;
    logic                           stall_wb_o;
    logic                           rf_we_o;
    logic [63:0]                    rf_wdata_o;
    logic                           retire_o;
    logic                           xcpt_o;
    logic [63:0]                    xcpt_cause_o;
    logic                           timeout_o;
    logic [63:0]                    retire_count_o;

    int n_cmp = 0;
    int n_err = 0;
    int stall_seen = 0;

    csr_wb_sequencer #(
        .DATA_WIDTH(64), .CSR_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TMO), .RETIRE_CNT_WIDTH(64)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i),
        .wb_valid_i(wb_valid_i), .wb_instr_type_i(wb_instr_type_i), .wb_rs1_i(wb_rs1_i),
        .wb_result_i(wb_result_i), .wb_csr_addr_i(wb_csr_addr_i), .wb_xcpt_i(wb_xcpt_i),
        .wb_xcpt_cause_i(wb_xcpt_cause_i), .wb_pc_i(wb_pc_i),
        .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
        .csr_cmd_o(csr_cmd_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_resp_valid_i(csr_resp_valid_i), .csr_rdata_i(csr_rdata_i),
        .csr_resp_xcpt_i(csr_resp_xcpt_i), .stall_wb_o(stall_wb_o),
        .rf_we_o(rf_we_o), .rf_wdata_o(rf_wdata_o), .retire_o(retire_o),
        .xcpt_o(xcpt_o), .xcpt_cause_o(xcpt_cause_o), .timeout_o(timeout_o),
        .retire_count_o(retire_count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (stall_wb_o) stall_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs IDLE, REQ (n_busy not-ready cycles first) and WAIT_RESP phases.
    // resp_at < 0 means no response: the access must time out after TMO wait cycles.
    task automatic do_csr(input instr_type_t t, input logic [4:0] rs1, input logic [63:0] res,
                          input logic [11:0] addr, input int n_busy, input int resp_at,
                          input logic rx, input logic [63:0] rdata,
                          input csr_cmd_t ecmd, input logic [63:0] ewd);
        int nw;
        wb_valid_i = 1'b1; wb_instr_type_i = t; wb_rs1_i = rs1;
        wb_result_i = res; wb_csr_addr_i = addr; wb_xcpt_i = 1'b0;
        csr_req_ready_i = (n_busy == 0);
        @(negedge clk);
        chk("idle_stall", 64'(stall_wb_o), 64'd1);
        chk("idle_noreq", 64'(csr_req_valid_o), 64'd0);
        cycle();
        for (int i = 0; i < n_busy; i++) begin
            @(negedge clk);
            chk("busy_valid", 64'(csr_req_valid_o), 64'd1);
            chk("busy_cmd",   64'(csr_cmd_o), 64'(ecmd));
            chk("busy_addr",  64'(csr_addr_o), 64'(addr));
            chk("busy_wdata", csr_wdata_o, ewd);
            cycle();
        end
        csr_req_ready_i = 1'b1;
        @(negedge clk);
        chk("req_valid", 64'(csr_req_valid_o), 64'd1);
        chk("req_cmd",   64'(csr_cmd_o), 64'(ecmd));
        chk("req_addr",  64'(csr_addr_o), 64'(addr));
        chk("req_wdata", csr_wdata_o, ewd);
        chk("req_stall", 64'(stall_wb_o), 64'd1);
        cycle();
        csr_req_ready_i = 1'b0;
        nw = (resp_at < 0) ? TMO : resp_at + 1;
        for (int j = 0; j < nw; j++) begin
            csr_resp_valid_i = (j == resp_at);
            csr_resp_xcpt_i  = (j == resp_at) ? rx : 1'b0;
            csr_rdata_i      = rdata;
            @(negedge clk);
            chk("wait_stall", 64'(stall_wb_o), 64'd1);
            chk("wait_noreq", 64'(csr_req_valid_o), 64'd0);
            chk("wait_nowe",  64'(rf_we_o), 64'd0);
            cycle();
        end
        csr_resp_valid_i = 1'b0;
        csr_resp_xcpt_i  = 1'b0;
    endtask

    task automatic chk_done(input logic we, input logic [63:0] wd, input logic ret,
                            input logic xc, input logic [63:0] cause);
        @(negedge clk);
        chk("done_stall", 64'(stall_wb_o), 64'd0);
        chk("done_we",    64'(rf_we_o), 64'(we));
        chk("done_wdata", rf_wdata_o, wd);
        chk("done_ret",   64'(retire_o), 64'(ret));
        chk("done_xcpt",  64'(xcpt_o), 64'(xc));
        chk("done_cause", xcpt_cause_o, cause);
        cycle();
        wb_valid_i = 1'b0;
    endtask

    initial begin
        int s0;
        rstn_i = 1'b0; flush_i = 1'b0; wb_valid_i = 1'b1; wb_instr_type_i = ADD;
        wb_rs1_i = '0; wb_result_i = '0; wb_csr_addr_i = '0; wb_xcpt_i = 1'b0;
        wb_xcpt_cause_i = '0; wb_pc_i = 64'h8000_0000; csr_req_ready_i = 1'b0;
        csr_resp_valid_i = 1'b0; csr_rdata_i = '0; csr_resp_xcpt_i = 1'b0;

        // Reset: a valid ADD must not pulse retire while reset is held.
        cycle(); cycle();
        @(negedge clk);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_reqv",   64'(csr_req_valid_o), 64'd0);
        chk("rst_cmd",    64'(csr_cmd_o), 64'(CSR_CMD_NOPE));
        chk("rst_stall",  64'(stall_wb_o), 64'd0);
        chk("rst_tmo",    64'(timeout_o), 64'd0);
        cycle();
        rstn_i = 1'b1; wb_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_count", retire_count_o, 64'd0);
        cycle();

        // CSRRW: response on the 2nd wait cycle; 4 stall cycles in total.
        s0 = stall_seen;
        do_csr(CSRRW, 5'd7, 64'hDEAD, 12'h300, 0, 1, 1'b0, 64'h1234, CSR_CMD_WRITE, 64'hDEAD);
        chk_done(1'b1, 64'h1234, 1'b1, 1'b0, 64'd0);
        chk("rw_stall_cycles", 64'(stall_seen - s0), 64'd4);
        chk("rw_count", retire_count_o, 64'd1);

        // CSRRSI rs1=0 degrades to READ with zero write data; immediate response.
        do_csr(CSRRSI, 5'd0, 64'hFFFF, 12'h341, 0, 0, 1'b0, 64'h77, CSR_CMD_READ, 64'd0);
        chk_done(1'b1, 64'h77, 1'b1, 1'b0, 64'd0);

        // CSRRCI rs1=5 with ready held low 3 cycles.
        do_csr(CSRRCI, 5'd5, 64'hFFFF, 12'h305, 3, 1, 1'b0, 64'hABC, CSR_CMD_CLEAR, 64'd5);
        chk_done(1'b1, 64'hABC, 1'b1, 1'b0, 64'd0);
        chk("clr_count", retire_count_o, 64'd3);

        // Timeout: no response for 16 wait cycles; a late response in DONE is ignored.
        do_csr(CSRRW, 5'd1, 64'h55, 12'h340, 0, -1, 1'b0, 64'h0, CSR_CMD_WRITE, 64'h55);
        csr_resp_valid_i = 1'b1; csr_rdata_i = 64'h99;
        chk_done(1'b0, 64'd0, 1'b0, 1'b1, 64'd2);
        csr_resp_valid_i = 1'b0;
        @(negedge clk);
        chk("tmo_sticky", 64'(timeout_o), 64'd1);
        chk("tmo_count",  retire_count_o, 64'd3);
        chk("tmo_idle",   64'(stall_wb_o), 64'd0);
        cycle();

        // Flush in WAIT_RESP: drain, then response 4 cycles after the flush is discarded.
        wb_valid_i = 1'b1; wb_instr_type_i = CSRRS; wb_rs1_i = 5'd3;
        wb_result_i = 64'hF0; wb_csr_addr_i = 12'h344; csr_req_ready_i = 1'b1;
        cycle();
        @(negedge clk);
        chk("fl_req_cmd", 64'(csr_cmd_o), 64'(CSR_CMD_SET));
        cycle();
        csr_req_ready_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        chk("fl_wait_stall", 64'(stall_wb_o), 64'd1);
        cycle();
        flush_i = 1'b0; wb_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_stall", 64'(stall_wb_o), 64'd0);
        cycle();
        wb_valid_i = 1'b1; wb_instr_type_i = CSRRW;
        @(negedge clk);
        chk("drain_csr_stall", 64'(stall_wb_o), 64'd1);
        cycle();
        wb_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_no_accept", 64'(csr_req_valid_o), 64'd0);
        cycle();
        csr_resp_valid_i = 1'b1; csr_rdata_i = 64'hFF;
        @(negedge clk);
        chk("drain_nowe",  64'(rf_we_o), 64'd0);
        chk("drain_noret", 64'(retire_o), 64'd0);
        cycle();
        csr_resp_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_instr_type_i = ADD;
        @(negedge clk);
        chk("add_retire", 64'(retire_o), 64'd1);
        chk("add_nowe",   64'(rf_we_o), 64'd0);
        cycle();
        wb_valid_i = 1'b0;
        @(negedge clk);
        chk("add_count", retire_count_o, 64'd4);
        cycle();

        // Carried exception: pass-through cause, no request, no retire.
        wb_valid_i = 1'b1; wb_instr_type_i = CSRRW; wb_xcpt_i = 1'b1; wb_xcpt_cause_i = 64'h2;
        @(negedge clk);
        chk("wbx_xcpt",  64'(xcpt_o), 64'd1);
        chk("wbx_cause", xcpt_cause_o, 64'h2);
        chk("wbx_stall", 64'(stall_wb_o), 64'd0);
        cycle();
        wb_valid_i = 1'b0; wb_xcpt_i = 1'b0;
        @(negedge clk);
        chk("wbx_noreq", 64'(csr_req_valid_o), 64'd0);
        chk("wbx_count", retire_count_o, 64'd4);
        cycle();

        // Flush in IDLE suppresses retire; flush in REQ aborts without a request.
        wb_valid_i = 1'b1; wb_instr_type_i = ADD; flush_i = 1'b1;
        @(negedge clk);
        chk("fl_idle_ret", 64'(retire_o), 64'd0);
        cycle();
        flush_i = 1'b0; wb_instr_type_i = CSRRWI; wb_rs1_i = 5'd9;
        cycle();
        flush_i = 1'b1; wb_valid_i = 1'b0; csr_req_ready_i = 1'b1;
        @(negedge clk);
        chk("fl_req_novalid", 64'(csr_req_valid_o), 64'd0);
        cycle();
        flush_i = 1'b0; csr_req_ready_i = 1'b0;
        @(negedge clk);
        chk("fl_req_idle", 64'(stall_wb_o), 64'd0);
        chk("fl_req_cmd2", 64'(csr_cmd_o), 64'(CSR_CMD_NOPE));
        cycle();

        // Faulting CSR response: illegal-instruction trap, no write-back.
        do_csr(CSRRC, 5'd2, 64'h3, 12'h7C0, 1, 2, 1'b1, 64'h42, CSR_CMD_CLEAR, 64'h3);
        chk_done(1'b0, 64'd0, 1'b0, 1'b1, 64'd2);
        @(negedge clk);
        chk("final_count", retire_count_o, 64'd4);
        chk("final_tmo",   64'(timeout_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
